// File: rtl/dual_issue_packer.sv
// dual_issue_packer: gathers a single-wide valid/ready stream into oldest-first pairs
// for a dual-issue FIFO write port, releasing a lone entry after a bounded wait.
`default_nettype none

module dual_issue_packer #(
  parameter int Width       = 32,
  parameter int PairTimeout = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             drain_i,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_rdy_o,
  output logic [1:0]       out_valid_o,
  output logic [Width-1:0] out_data0_o,
  output logic [Width-1:0] out_data1_o,
  input  logic [1:0]       out_rdy_i
);

  localparam int AW = (PairTimeout > 0) ? $clog2(PairTimeout + 1) : 1;
  localparam logic [AW-1:0] AGE_MAX = AW'(PairTimeout);

  logic [Width-1:0] buf0_q, buf0_d;
  logic [Width-1:0] buf1_q, buf1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [AW-1:0]    age_q, age_d;

  logic [1:0] rdy_eff;
  logic [1:0] n_out;
  logic [1:0] rem;
  logic       acc;
  logic       load0;

  always_comb begin
    // 2'b10 is not a legal grant; treat it as no room at all
    rdy_eff = (out_rdy_i == 2'b10) ? 2'b00 : out_rdy_i;

    out_valid_o = 2'b00;
    if (cnt_q == 2'd2) begin
      out_valid_o = 2'b11;
    end else if (cnt_q == 2'd1 && (age_q >= AGE_MAX || drain_i)) begin
      out_valid_o = 2'b01;
    end

    n_out = 2'd0;
    if (out_valid_o == 2'b11 && rdy_eff == 2'b11) begin
      n_out = 2'd2;
    end else if (out_valid_o[0] && rdy_eff[0]) begin
      n_out = 2'd1;
    end

    rem      = cnt_q - n_out;
    in_rdy_o = (rem < 2'd2);
    acc      = in_valid_i & in_rdy_o;

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    load0  = 1'b0;
    if (n_out == 2'd1 && cnt_q == 2'd2) begin
      buf0_d = buf1_q;
      load0  = 1'b1;
    end
    if (acc) begin
      if (rem == 2'd0) begin
        buf0_d = in_data_i;
        load0  = 1'b1;
      end else begin
        buf1_d = in_data_i;
      end
    end

    cnt_d = rem + {1'b0, acc};

    // age tracks how long the current head has been waiting alone
    age_d = age_q;
    if (cnt_d != 2'd1 || load0) begin
      age_d = '0;
    end else if (cnt_q == 2'd1 && age_q < AGE_MAX) begin
      age_d = age_q + 1'b1;
    end

    if (flush_i) begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      cnt_d  = 2'd0;
      age_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q  <= 2'd0;
      age_q  <= '0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
    end
  end

  assign out_data0_o = buf0_q;
  assign out_data1_o = buf1_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_issue_packer.sv
// Self-checking bench: four packers with different timeouts share one stimulus;
// each scenario checks the instance it targets, then a random run against a queue model.
`default_nettype none

module tb_dual_issue_packer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        drain;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  out_rdy;

  logic        in_rdy [4];
  logic [1:0]  ov     [4];
  logic [31:0] od0    [4];
  logic [31:0] od1    [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dual_issue_packer #(.Width(32), .PairTimeout(0)) u_p0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .drain_i(drain),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_rdy_o(in_rdy[0]),
    .out_valid_o(ov[0]), .out_data0_o(od0[0]), .out_data1_o(od1[0]), .out_rdy_i(out_rdy));

  dual_issue_packer #(.Width(32), .PairTimeout(3)) u_p3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .drain_i(drain),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_rdy_o(in_rdy[1]),
    .out_valid_o(ov[1]), .out_data0_o(od0[1]), .out_data1_o(od1[1]), .out_rdy_i(out_rdy));

  dual_issue_packer #(.Width(32), .PairTimeout(7)) u_p7 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .drain_i(drain),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_rdy_o(in_rdy[2]),
    .out_valid_o(ov[2]), .out_data0_o(od0[2]), .out_data1_o(od1[2]), .out_rdy_i(out_rdy));

  dual_issue_packer #(.Width(32), .PairTimeout(2)) u_p2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .drain_i(drain),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_rdy_o(in_rdy[3]),
    .out_valid_o(ov[3]), .out_data0_o(od0[3]), .out_data1_o(od1[3]), .out_rdy_i(out_rdy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    drain    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    out_rdy  = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ov[k] !== 2'b00 || in_rdy[k] !== 1'b1 || od0[k] !== 32'd0 || od1[k] !== 32'd0) begin
        errors++;
        $display("FAIL reset inst%0d: valid=%b rdy=%b d0=%h d1=%h, want 00 1 0 0",
                 k, ov[k], in_rdy[k], od0[k], od1[k]);
      end
    end
  endtask

  task automatic test_pack_no_timeout();
    do_reset();
    out_rdy = 2'b00; in_valid = 1'b1; in_data = 32'hA0A0_0001;
    #1;
    checks++;
    if (in_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL pt0_rdy_empty: got %b want 1", in_rdy[0]);
    end
    tick();
    in_data = 32'hB0B0_0002;
    #1;
    checks++;
    if (ov[0] !== 2'b01 || od0[0] !== 32'hA0A0_0001) begin
      errors++; $display("FAIL pt0_single: valid=%b d0=%h want 01 a0a00001", ov[0], od0[0]);
    end
    tick();
    in_data = 32'hC0C0_0003;
    #1;
    checks++;
    if (ov[0] !== 2'b11 || od0[0] !== 32'hA0A0_0001 || od1[0] !== 32'hB0B0_0002 || in_rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL pt0_pair: valid=%b d0=%h d1=%h rdy=%b want 11 a0a00001 b0b00002 0",
               ov[0], od0[0], od1[0], in_rdy[0]);
    end
    tick();
    out_rdy = 2'b11;
    #1;
    checks++;
    if (in_rdy[0] !== 1'b1 || ov[0] !== 2'b11) begin
      errors++; $display("FAIL pt0_passback: rdy=%b valid=%b want 1 11", in_rdy[0], ov[0]);
    end
    tick();
    in_valid = 1'b0; out_rdy = 2'b00;
    #1;
    checks++;
    if (ov[0] !== 2'b01 || od0[0] !== 32'hC0C0_0003) begin
      errors++; $display("FAIL pt0_c_head: valid=%b d0=%h want 01 c0c00003", ov[0], od0[0]);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    out_rdy = 2'b11; in_valid = 1'b1; in_data = 32'h0000_00AA;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ov[1] !== 2'b00) begin
        errors++; $display("FAIL pt3_wait%0d: valid=%b want 00", i, ov[1]);
      end
      tick();
    end
    checks++;
    if (ov[1] !== 2'b01 || od0[1] !== 32'h0000_00AA) begin
      errors++; $display("FAIL pt3_release: valid=%b d0=%h want 01 000000aa", ov[1], od0[1]);
    end
    tick();
    checks++;
    if (ov[1] !== 2'b00) begin
      errors++; $display("FAIL pt3_drained: valid=%b want 00", ov[1]);
    end

    do_reset();
    in_valid = 1'b1; in_data = 32'h0000_0A01;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 32'h0000_0B02;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (ov[1] !== 2'b11 || od0[1] !== 32'h0000_0A01 || od1[1] !== 32'h0000_0B02) begin
      errors++; $display("FAIL pt3_partner: valid=%b d0=%h d1=%h want 11 a01 b02", ov[1], od0[1], od1[1]);
    end
    out_rdy = 2'b01;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[1] !== 2'b00 || od0[1] !== 32'h0000_0B02) begin
        errors++; $display("FAIL pt3_age_restart%0d: valid=%b d0=%h want 00 b02", i, ov[1], od0[1]);
      end
      tick();
    end
    checks++;
    if (ov[1] !== 2'b01) begin
      errors++; $display("FAIL pt3_b_release: valid=%b want 01", ov[1]);
    end
  endtask

  task automatic test_drain();
    do_reset();
    in_valid = 1'b1; in_data = 32'hD0D0_0007;
    tick();
    in_valid = 1'b0; out_rdy = 2'b11;
    #1;
    checks++;
    if (ov[2] !== 2'b00) begin
      errors++; $display("FAIL drain_hold: valid=%b want 00", ov[2]);
    end
    drain = 1'b1;
    #1;
    checks++;
    if (ov[2] !== 2'b01 || od0[2] !== 32'hD0D0_0007) begin
      errors++; $display("FAIL drain_offer: valid=%b d0=%h want 01 d0d00007", ov[2], od0[2]);
    end
    tick();
    checks++;
    if (ov[2] !== 2'b00 || in_rdy[2] !== 1'b1) begin
      errors++; $display("FAIL drain_taken: valid=%b rdy=%b want 00 1", ov[2], in_rdy[2]);
    end
    drain = 1'b0;
  endtask

  task automatic test_partial_rdy();
    do_reset();
    in_valid = 1'b1; in_data = 32'h1111_0001;
    tick();
    in_data = 32'h2222_0002;
    tick();
    in_data = 32'h3333_0003; out_rdy = 2'b01;
    #1;
    checks++;
    if (in_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL partial_rdy: in_rdy=%b want 1", in_rdy[0]);
    end
    tick();
    in_valid = 1'b0; out_rdy = 2'b00;
    #1;
    checks++;
    if (ov[0] !== 2'b11 || od0[0] !== 32'h2222_0002 || od1[0] !== 32'h3333_0003) begin
      errors++; $display("FAIL partial_shift: valid=%b d0=%h d1=%h want 11 22220002 33330003",
                         ov[0], od0[0], od1[0]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = 32'h4444_0001;
    tick();
    in_data = 32'h4444_0002;
    tick();
    flush = 1'b1; out_rdy = 2'b11; in_data = 32'h4444_0003;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_rdy = 2'b00;
    #1;
    checks++;
    if (ov[0] !== 2'b00 || in_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL flush_empty: valid=%b rdy=%b want 00 1", ov[0], in_rdy[0]);
    end
    in_valid = 1'b1; in_data = 32'hDDDD_0004;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 2'b01 || od0[0] !== 32'hDDDD_0004) begin
      errors++; $display("FAIL flush_refill: valid=%b d0=%h want 01 dddd0004", ov[0], od0[0]);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    in_valid = 1'b1; in_data = 32'h5555_0001;
    tick();
    in_data = 32'h5555_0002;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 2'b00 || in_rdy[0] !== 1'b1 || od0[0] !== 32'd0) begin
      errors++; $display("FAIL reset_mid: valid=%b rdy=%b d0=%h want 00 1 0", ov[0], in_rdy[0], od0[0]);
    end
  endtask

  // Reference: a FIFO of held entries plus how long the current head has waited alone.
  task automatic test_random();
    logic [31:0] q[$];
    int          qid[$];
    int          age;
    int          next_id;
    int          head_before;
    int          sz;
    int          nout;
    logic [1:0]  exp_v;
    logic        exp_rdy;
    int          r;
    do_reset();
    age = 0;
    next_id = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = $urandom_range(0, 2);
      out_rdy  = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      drain    = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 59) == 0);
      #1;
      sz = q.size();
      if (sz >= 2) exp_v = 2'b11;
      else if (sz == 1 && (age >= 2 || drain)) exp_v = 2'b01;
      else exp_v = 2'b00;

      checks++;
      if (ov[3] !== exp_v || ov[3] === 2'b10) begin
        errors++; $display("FAIL rand_valid cyc%0d: got %b want %b", cyc, ov[3], exp_v);
      end
      if (exp_v[0]) begin
        checks++;
        if (od0[3] !== q[0]) begin
          errors++; $display("FAIL rand_d0 cyc%0d: got %h want %h", cyc, od0[3], q[0]);
        end
      end
      if (exp_v[1]) begin
        checks++;
        if (od1[3] !== q[1]) begin
          errors++; $display("FAIL rand_d1 cyc%0d: got %h want %h", cyc, od1[3], q[1]);
        end
      end

      if (exp_v == 2'b11 && out_rdy == 2'b11) nout = 2;
      else if (exp_v[0] && out_rdy[0]) nout = 1;
      else nout = 0;
      exp_rdy = ((sz - nout) < 2);
      checks++;
      if (in_rdy[3] !== exp_rdy) begin
        errors++; $display("FAIL rand_in_rdy cyc%0d: got %b want %b", cyc, in_rdy[3], exp_rdy);
      end

      head_before = (sz > 0) ? qid[0] : -1;
      if (flush) begin
        q.delete();
        qid.delete();
      end else begin
        for (int i = 0; i < nout; i++) begin
          void'(q.pop_front());
          void'(qid.pop_front());
        end
        if (in_valid && exp_rdy) begin
          q.push_back(in_data);
          qid.push_back(next_id);
          next_id++;
        end
      end
      if (q.size() != 1 || qid[0] != head_before) age = 0;
      else if (age < 2) age++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_pack_no_timeout();
    test_timeout();
    test_drain();
    test_partial_rdy();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
